// File: rtl/canny_pkg.sv
// Shared definitions for the Canny chain: FSM states, frame geometry and
// threshold defaults used by frame control, nms and hysteresis.
package canny_pkg;

    localparam int unsigned CANNY_H_ACT = 640;
    localparam int unsigned CANNY_V_ACT = 480;
    localparam int unsigned CANNY_CW    = 11;
    localparam int unsigned TH_W        = 8;
    localparam int unsigned CANNY_TH_HI = 80;
    localparam int unsigned CANNY_TH_LO = 40;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_VS = 3'd1,
        ST_WAIT_DE = 3'd2,
        ST_ACTIVE  = 3'd3,
        ST_DONE    = 3'd4
    } frame_state_t;

    typedef struct packed {
        logic [TH_W-1:0] hi;
        logic [TH_W-1:0] lo;
    } thresh_t;

endpackage

// File: rtl/canny_frame_ctrl_if.sv
// Video timing bus: sobel sync/enable in, aligned pixel position out.
interface canny_frame_ctrl_if
    import canny_pkg::*;
#(
    parameter int unsigned CW = CANNY_CW
);
    logic          in_hs;
    logic          in_vs;
    logic          in_de;
    logic          pix_de;
    logic          border;
    logic [CW-1:0] col;
    logic [CW-1:0] row;

    modport master (
        output in_hs, in_vs, in_de,
        input  pix_de, border, col, row
    );

    modport slave (
        input  in_hs, in_vs, in_de,
        output pix_de, border, col, row
    );
endinterface

// File: rtl/canny_pos_cnt.sv
// Column/row counters with de edge detect, line length / overrun checks and
// border flag, all registered and aligned to pix_de.
module canny_pos_cnt #(
    parameter int unsigned H_ACT = 640,
    parameter int unsigned V_ACT = 480,
    parameter int unsigned CW    = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cnt_en,
    input  logic          clr,
    input  logic          de,
    output logic          pix_de,
    output logic          border,
    output logic [CW-1:0] col,
    output logic [CW-1:0] row,
    output logic          line_end_c,
    output logic          err_c
);
    localparam logic [CW-1:0] H_END  = CW'(H_ACT);
    localparam logic [CW-1:0] H_LAST = CW'(H_ACT - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_ACT - 1);

    logic          de_q;
    logic          ovr_seen;
    logic [CW-1:0] col_cnt;
    logic [CW-1:0] row_cnt;
    logic          pix_c;
    logic          fall_c;
    logic          ovr_c;
    logic          edge_c;

    // Overrun reports once per line; col_cnt saturates at H_ACT.
    always_comb begin
        pix_c      = cnt_en && de;
        fall_c     = cnt_en && de_q && !de;
        ovr_c      = pix_c && (col_cnt == H_END) && !ovr_seen;
        edge_c     = (row_cnt == '0) || (row_cnt == V_LAST) ||
                     (col_cnt == '0) || (col_cnt >= H_LAST);
        line_end_c = fall_c && (row_cnt == V_LAST);
        err_c      = !clr && (ovr_c || (fall_c && (col_cnt != H_END)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            de_q     <= 1'b0;
            ovr_seen <= 1'b0;
            col_cnt  <= '0;
            row_cnt  <= '0;
            pix_de   <= 1'b0;
            border   <= 1'b0;
            col      <= '0;
            row      <= '0;
        end else begin
            de_q <= de;
            if (clr) begin
                ovr_seen <= 1'b0;
                col_cnt  <= '0;
                row_cnt  <= '0;
                pix_de   <= 1'b0;
                border   <= 1'b0;
                col      <= '0;
                row      <= '0;
            end else begin
                pix_de <= pix_c;
                border <= pix_c && edge_c;
                if (pix_c) begin
                    col <= col_cnt;
                    row <= row_cnt;
                    if (col_cnt == H_END) begin
                        ovr_seen <= 1'b1;
                    end else begin
                        col_cnt <= col_cnt + CW'(1);
                    end
                end
                // A line counts even when its length was wrong.
                if (fall_c) begin
                    col_cnt  <= '0;
                    row_cnt  <= row_cnt + CW'(1);
                    ovr_seen <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/canny_frame_ctrl.sv
// Frame sequencer for sobel -> nms -> hysteresis: frame FSM, double-buffered
// thresholds committed on in_vs rise, frame_done / err_len reporting.
module canny_frame_ctrl
    import canny_pkg::*;
#(
    parameter int unsigned H_ACT     = CANNY_H_ACT,
    parameter int unsigned V_ACT     = CANNY_V_ACT,
    parameter int unsigned CW        = CANNY_CW,
    parameter int unsigned TH_HI_DEF = CANNY_TH_HI,
    parameter int unsigned TH_LO_DEF = CANNY_TH_LO
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_en,
    input  logic            cfg_we,
    input  logic [TH_W-1:0] cfg_th_hi,
    input  logic [TH_W-1:0] cfg_th_lo,
    canny_frame_ctrl_if.slave bus,
    output logic [TH_W-1:0] th_hi,
    output logic [TH_W-1:0] th_lo,
    output logic            busy,
    output logic            frame_done,
    output logic            err_len
);
    localparam thresh_t TH_DEF = '{hi: TH_W'(TH_HI_DEF), lo: TH_W'(TH_LO_DEF)};

    frame_state_t state;
    frame_state_t nxt;
    thresh_t      pend;
    thresh_t      cfg_c;
    logic         vs_q;
    logic         vs_rise_c;
    logic         load_c;
    logic         trunc_c;
    logic         cnt_en_c;
    logic         pos_err_c;
    logic         line_end_c;
    logic         err_any_c;
    logic         err_seen;

    canny_pos_cnt #(
        .H_ACT(H_ACT),
        .V_ACT(V_ACT),
        .CW   (CW)
    ) u_pos (
        .clk       (clk),
        .rst       (rst),
        .cnt_en    (cnt_en_c),
        .clr       (load_c),
        .de        (bus.in_de),
        .pix_de    (bus.pix_de),
        .border    (bus.border),
        .col       (bus.col),
        .row       (bus.row),
        .line_end_c(line_end_c),
        .err_c     (pos_err_c)
    );

    // cfg_en is only honoured between frames, so a started frame always ends.
    always_comb begin
        nxt       = state;
        load_c    = 1'b0;
        trunc_c   = 1'b0;
        vs_rise_c = bus.in_vs && !vs_q;
        cnt_en_c  = (state == ST_WAIT_DE) || (state == ST_ACTIVE);
        cfg_c     = '{hi: cfg_th_hi, lo: cfg_th_lo};
        unique case (state)
            ST_IDLE: begin
                if (cfg_en) nxt = ST_WAIT_VS;
            end
            ST_WAIT_VS: begin
                if (!cfg_en) begin
                    nxt = ST_IDLE;
                end else if (vs_rise_c) begin
                    nxt    = ST_WAIT_DE;
                    load_c = 1'b1;
                end
            end
            ST_WAIT_DE: begin
                if (bus.in_de) nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (vs_rise_c) begin
                    nxt     = ST_WAIT_DE;
                    load_c  = 1'b1;
                    trunc_c = 1'b1;
                end else if (line_end_c) begin
                    nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                nxt = cfg_en ? ST_WAIT_VS : ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
        err_any_c = pos_err_c || trunc_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            vs_q       <= 1'b0;
            pend       <= TH_DEF;
            th_hi      <= TH_DEF.hi;
            th_lo      <= TH_DEF.lo;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err_len    <= 1'b0;
            err_seen   <= 1'b0;
        end else begin
            state      <= nxt;
            vs_q       <= bus.in_vs;
            busy       <= (nxt == ST_WAIT_DE) || (nxt == ST_ACTIVE);
            err_len    <= err_any_c;
            frame_done <= (nxt == ST_DONE) && !err_seen && !err_any_c;
            if (cfg_we) pend <= cfg_c;
            // A write landing on the commit cycle bypasses the pending stage.
            if (load_c) begin
                th_hi <= cfg_we ? cfg_c.hi : pend.hi;
                th_lo <= cfg_we ? cfg_c.lo : pend.lo;
            end
            if (load_c) begin
                err_seen <= 1'b0;
            end else if (err_any_c) begin
                err_seen <= 1'b1;
            end
        end
    end

    hs_de_overlap: assert property (@(posedge clk) disable iff (rst) !(bus.in_hs && bus.in_de));

endmodule

// File: tb/tb_canny_frame_ctrl.sv
// Randomized frame bench for canny_frame_ctrl on an 8x4 frame with a
// line-level reference model of positions, errors and thresholds.
module tb_canny_frame_ctrl;
    localparam int unsigned H  = 8;
    localparam int unsigned V  = 4;
    localparam int unsigned CW = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_en;
    logic       cfg_we;
    logic [7:0] cfg_th_hi;
    logic [7:0] cfg_th_lo;
    logic [7:0] th_hi;
    logic [7:0] th_lo;
    logic       busy;
    logic       frame_done;
    logic       err_len;

    always #5 clk = ~clk;

    canny_frame_ctrl_if #(.CW(CW)) bus ();

    canny_frame_ctrl #(
        .H_ACT(H), .V_ACT(V), .CW(CW), .TH_HI_DEF(80), .TH_LO_DEF(40)
    ) dut (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_we(cfg_we),
        .cfg_th_hi(cfg_th_hi), .cfg_th_lo(cfg_th_lo), .bus(bus),
        .th_hi(th_hi), .th_lo(th_lo), .busy(busy),
        .frame_done(frame_done), .err_len(err_len)
    );

    int n_vec = 0;
    int n_err = 0;

    // reference state
    int pend_hi = 80, pend_lo = 40, act_hi = 80, act_lo = 40;
    bit ld = 0, busy_m = 0, dead = 0;
    int lens[V];
    int we_line = -1, we_pix = 0, en_off_line = -1, rst_line = -1, rst_pix = 0, ab_after = -1;
    bit we_vs = 0;

    task automatic chk(input string tag, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    // One clock: drive inputs, then compare registered outputs 1 ns after the edge.
    task automatic step(input bit vs, input bit hs, input bit de, input bit ep,
                        input int ec, input int er, input bit eb, input bit ee, input bit ed);
        bus.in_vs = vs;
        bus.in_hs = hs;
        bus.in_de = de;
        if (rst) begin
            pend_hi = 80; pend_lo = 40; act_hi = 80; act_lo = 40;
        end else begin
            if (cfg_we) begin pend_hi = int'(cfg_th_hi); pend_lo = int'(cfg_th_lo); end
            if (ld) begin act_hi = pend_hi; act_lo = pend_lo; end
        end
        if (dead) begin ep = 0; ee = 0; ed = 0; end
        @(posedge clk);
        #1;
        chk("pix_de", int'(bus.pix_de), int'(ep));
        if (ep) begin
            chk("col", int'(bus.col), ec);
            chk("row", int'(bus.row), er);
            chk("border", int'(bus.border), int'(eb));
        end
        chk("err_len", int'(err_len), int'(ee));
        chk("frame_done", int'(frame_done), int'(ed));
        chk("busy", int'(busy), int'(busy_m));
        chk("th_hi", int'(th_hi), act_hi);
        chk("th_lo", int'(th_lo), act_lo);
        cfg_we = 1'b0;
        ld     = 1'b0;
    endtask

    task automatic quiet(input bit vs, input bit hs, input bit de);
        step(vs, hs, de, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic new_cfg();
        cfg_we    = 1'b1;
        cfg_th_hi = 8'($urandom_range(0, 255));
        cfg_th_lo = 8'($urandom_range(0, 255));
    endtask

    task automatic run_frame(input bit trunc_in, output bit aborted);
        bit clean, last, e, d, eb;
        int nb;
        clean   = 1;
        aborted = 0;
        if (we_vs) new_cfg();
        ld     = 1;
        busy_m = 1;
        step(1, 0, 0, 0, 0, 0, 0, trunc_in, 0);
        quiet(0, 0, 0);
        for (int l = 0; l < int'(V); l++) begin
            for (int i = 0; i < lens[l]; i++) begin
                if (l == we_line && i == we_pix) new_cfg();
                if (l == en_off_line && i == 0) cfg_en = 1'b0;
                if (l == rst_line && i == rst_pix) begin
                    rst = 1'b1; dead = 1; busy_m = 0;
                end
                eb = (l == 0) || (l == int'(V) - 1) || (i == 0) || (i >= int'(H) - 1);
                step(0, 0, 1, 1, (i < int'(H)) ? i : int'(H), l, eb, i == int'(H), 0);
                if (rst) begin
                    chk("col_after_rst", int'(bus.col), 0);
                    chk("row_after_rst", int'(bus.row), 0);
                    chk("border_after_rst", int'(bus.border), 0);
                    rst = 1'b0;
                end
                if (i == int'(H)) clean = 0;
            end
            last = (l == int'(V) - 1);
            e    = (lens[l] < int'(H));
            if (e) clean = 0;
            if (last) busy_m = 0;
            d = last && clean;
            step(0, 1, 0, 0, 0, 0, 0, e, d);
            nb = 2 + int'($urandom_range(0, 1));
            for (int b = 1; b < nb; b++) quiet(0, 0, 0);
            if (l == ab_after) begin
                ab_after = -1;
                aborted  = 1;
                return;
            end
        end
    endtask

    task automatic frame();
        bit ab;
        dead = 0;
        run_frame(0, ab);
        if (ab) run_frame(1, ab);
        we_line = -1; we_vs = 0; en_off_line = -1; rst_line = -1;
    endtask

    task automatic set_lens(input int a, input int b, input int c, input int d);
        lens[0] = a; lens[1] = b; lens[2] = c; lens[3] = d;
    endtask

    function automatic int rand_len();
        int r;
        r = int'($urandom_range(0, 9));
        return (r == 0) ? int'(H) - 1 : (r == 1) ? int'(H) + 1 : int'(H);
    endfunction

    initial begin
        rst = 1'b1; cfg_en = 1'b0; cfg_we = 1'b0;
        cfg_th_hi = '0; cfg_th_lo = '0;
        bus.in_vs = 1'b0; bus.in_hs = 1'b0; bus.in_de = 1'b0;
        quiet(0, 0, 0);
        chk("col_reset", int'(bus.col), 0);
        chk("row_reset", int'(bus.row), 0);
        chk("border_reset", int'(bus.border), 0);
        rst = 1'b0;
        cfg_en = 1'b1;
        quiet(0, 0, 0);
        quiet(0, 0, 0);

        // clean frame with a mid-frame threshold write that waits for next vs
        set_lens(8, 8, 8, 8); we_line = 1; we_pix = 3; frame();
        // write on the vs-rise cycle, short line 2
        we_vs = 1; set_lens(8, 8, 7, 8); frame();
        // long line 1
        set_lens(8, 9, 8, 8); frame();
        // truncated frame after line 0, then a full restart
        set_lens(8, 8, 8, 8); ab_after = 0; frame();
        // reset pulse during line 2
        we_line = 0; we_pix = 2; rst_line = 2; rst_pix = 3; frame();
        frame();
        // cfg_en drop mid-frame: frame completes, then sequencer parks
        en_off_line = 1; frame();
        quiet(1, 0, 0);
        quiet(0, 0, 0);
        for (int i = 0; i < 4; i++) quiet(0, 0, 1);
        quiet(0, 1, 0);
        cfg_en = 1'b1;
        quiet(0, 0, 0);
        quiet(0, 0, 0);

        // randomized frames
        for (int f = 0; f < 8; f++) begin
            for (int l = 0; l < int'(V); l++) lens[l] = rand_len();
            we_vs = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 1) begin
                we_line = int'($urandom_range(0, V - 1));
                we_pix  = int'($urandom_range(0, H - 2));
            end
            if ($urandom_range(0, 4) == 0) ab_after = int'($urandom_range(0, V - 2));
            frame();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
